// File: rtl/phy_rx_pkg.sv
// Shared receive-path definitions: alignment symbol, lock depth and FSM states.
// The lane demux stage imports the same COM definition.
package phy_rx_pkg;

  localparam logic [7:0] COM              = 8'hBC;
  localparam int         COM_LOCK_DEFAULT = 4;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    ALIGN  = 2'd1,
    ACTIVE = 2'd2
  } rx_state_e;

  function automatic logic is_com(input logic [7:0] b);
    return b == COM;
  endfunction

endpackage

// File: rtl/serial_to_parallel_rx_if.sv
// Serial-in / byte-out bundle of the receive converter.
// slave is the converter side, master is whoever drives the line and consumes bytes.
interface serial_to_parallel_rx_if;

  logic       data_in;
  logic [7:0] data_out;
  logic       valid_out;
  logic       byte_strb;
  logic       active;

  modport master (
    output data_in,
    input  data_out,
    input  valid_out,
    input  byte_strb,
    input  active
  );

  modport slave (
    input  data_in,
    output data_out,
    output valid_out,
    output byte_strb,
    output active
  );

endinterface

// File: rtl/serial_to_parallel_rx_shift8.sv
// 8-bit MSB-first shift register; cand is the byte ending with the bit on data_in.
// Only seven history bits are stored since the oldest one is never observable.
module rx_shift8 (
  input  logic       clk_32f,
  input  logic       reset,
  input  logic       data_in,
  output logic [7:0] cand
);

  logic [6:0] sr_reg;

  assign cand[0] = data_in;

  for (genvar gi = 1; gi < 8; gi++) begin : g_tap
    assign cand[gi] = sr_reg[gi-1];
  end

  always_ff @(posedge clk_32f) begin
    if (reset) begin
      sr_reg <= '0;
    end else begin
      sr_reg <= cand[6:0];
    end
  end

endmodule

// File: rtl/serial_to_parallel_rx.sv
// Receive serial-to-parallel converter: hunts COM at any bit offset, locks after
// COM_LOCK aligned COMs, then emits one byte per 8 bit-times (COM idles reported invalid).
module serial_to_parallel_rx
  import phy_rx_pkg::*;
#(
  parameter int COM_LOCK = COM_LOCK_DEFAULT
) (
  input  logic                    clk_32f,
  input  logic                    reset,
  serial_to_parallel_rx_if.slave  rx
);

  localparam logic [3:0] LOCK_CNT = 4'(COM_LOCK);

  logic [7:0] cand;
  rx_state_e  state_reg;
  logic [2:0] bit_cnt_reg;
  logic [3:0] com_cnt_reg;
  logic [7:0] data_out_reg;
  logic       valid_out_reg;
  logic       byte_strb_reg;
  logic       active_reg;
  logic       boundary;
  logic       cand_is_com;

  rx_shift8 u_shift (
    .clk_32f (clk_32f),
    .reset   (reset),
    .data_in (rx.data_in),
    .cand    (cand)
  );

  assign boundary    = (bit_cnt_reg == 3'd7);
  assign cand_is_com = is_com(cand);

  always_ff @(posedge clk_32f) begin
    if (reset) begin
      state_reg     <= HUNT;
      bit_cnt_reg   <= '0;
      com_cnt_reg   <= '0;
      data_out_reg  <= '0;
      valid_out_reg <= 1'b0;
      byte_strb_reg <= 1'b0;
      active_reg    <= 1'b0;
    end else begin
      byte_strb_reg <= 1'b0;
      case (state_reg)
        HUNT: begin
          if (cand_is_com) begin
            bit_cnt_reg <= '0;
            if (LOCK_CNT == 4'd1) begin
              state_reg   <= ACTIVE;
              active_reg  <= 1'b1;
              com_cnt_reg <= '0;
            end else begin
              state_reg   <= ALIGN;
              com_cnt_reg <= 4'd1;
            end
          end
        end
        ALIGN: begin
          bit_cnt_reg <= bit_cnt_reg + 3'd1;
          if (boundary) begin
            if (cand_is_com) begin
              if (com_cnt_reg + 4'd1 == LOCK_CNT) begin
                state_reg   <= ACTIVE;
                active_reg  <= 1'b1;
                com_cnt_reg <= '0;
              end else begin
                com_cnt_reg <= com_cnt_reg + 4'd1;
              end
            end else begin
              // Misaligned byte: drop back; the next hunt window starts next cycle.
              state_reg   <= HUNT;
              com_cnt_reg <= '0;
            end
          end
        end
        ACTIVE: begin
          // No resync once locked; only reset leaves this state.
          bit_cnt_reg <= bit_cnt_reg + 3'd1;
          if (boundary) begin
            data_out_reg  <= cand;
            valid_out_reg <= !cand_is_com;
            byte_strb_reg <= 1'b1;
          end
        end
        default: begin
          state_reg <= HUNT;
        end
      endcase
    end
  end

  assign rx.data_out  = data_out_reg;
  assign rx.valid_out = valid_out_reg;
  assign rx.byte_strb = byte_strb_reg;
  assign rx.active    = active_reg;

endmodule
